// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_arbiter
//  Description : Two-master to one-slave arbiter for the sram-like protocol.
//                Master 0 is the data port and master 1 is the instruction
//                port. An in-order owner FIFO sends every response back to
//                the master that issued the matching request.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (data)
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    // master 1 (instruction)
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    // slave
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] C_FULL_CNT   = CNT_W'(OUTST_DEPTH);
    localparam logic [STV_W-1:0] C_STARVE_MAX = STV_W'(STARVE_MAX);
    localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    // Owner FIFO state: one bit per outstanding transaction (0 = m0, 1 = m1)
    logic [OUTST_DEPTH-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Lock keeps the slave request stable until it is accepted
    logic                   lock_vld_q, lock_vld_d;
    logic                   lock_owner_q, lock_owner_d;

    logic [STV_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                   resp_err_q, resp_err_d;

    logic w_full;
    logic w_empty;
    logic w_grant_vld;
    logic w_grant_sel;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (count_q == C_FULL_CNT);
    assign w_empty = (count_q == '0);
    assign w_head  = owner_q[rd_ptr_q];

    // Grant selection: lock, then starvation rescue of m1, then m0, then m1
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_sel = 1'b0;
        if (lock_vld_q) begin
            w_grant_vld = 1'b1;
            w_grant_sel = lock_owner_q;
        end else if (m1_req && (starve_cnt_q == C_STARVE_MAX)) begin
            w_grant_vld = 1'b1;
            w_grant_sel = 1'b1;
        end else if (m0_req) begin
            w_grant_vld = 1'b1;
            w_grant_sel = 1'b0;
        end else if (m1_req) begin
            w_grant_vld = 1'b1;
            w_grant_sel = 1'b1;
        end
    end

    // Request path: combinational mux of the granted master onto the slave
    always_comb begin
        s_req    = w_grant_vld & ~w_full & ~rst;
        s_wr     = w_grant_sel ? m1_wr    : m0_wr;
        s_size   = w_grant_sel ? m1_size  : m0_size;
        s_wstrb  = w_grant_sel ? m1_wstrb : m0_wstrb;
        s_addr   = w_grant_sel ? m1_addr  : m0_addr;
        s_wdata  = w_grant_sel ? m1_wdata : m0_wdata;
    end

    assign w_accept   = s_req & s_addr_ok;
    assign m0_addr_ok = w_accept & ~w_grant_sel;
    assign m1_addr_ok = w_accept &  w_grant_sel;

    // Response path: route slave data_ok to the FIFO head owner
    assign w_push     = w_accept;
    assign w_pop      = s_data_ok & ~w_empty;
    assign m0_data_ok = w_pop & ~w_head & ~rst;
    assign m1_data_ok = w_pop &  w_head & ~rst;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    // Next-state for FIFO, lock, starvation counter and response error flag
    always_comb begin
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lock_vld_d   = lock_vld_q;
        lock_owner_d = lock_owner_q;
        starve_cnt_d = starve_cnt_q;
        resp_err_d   = resp_err_q;

        if (w_push) begin
            owner_d[wr_ptr_q] = w_grant_sel;
            wr_ptr_d          = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT_ONE;
        end

        if (w_accept) begin
            lock_vld_d = 1'b0;
        end else if (s_req) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = w_grant_sel;
        end

        if (!m1_req || m1_addr_ok) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != C_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end

        if (s_data_ok && w_empty) begin
            resp_err_d = 1'b1;
        end
    end

    // State registers with asynchronous reset; outstanding work is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= 1'b0;
            starve_cnt_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            starve_cnt_q <= starve_cnt_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_like_arbiter
//  Description : Directed self-checking bench for sram_like_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]  m0_size;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]  m1_size;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int n_checks;
    int n_fails;

    sram_like_arbiter #(
        .OUTST_DEPTH (4),
        .STARVE_MAX  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m1_rdata   (m1_rdata),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_wstrb = 4'hF; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_wstrb = 4'h0; m1_addr = 0; m1_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    // advance to just after the next rising edge; inputs are then driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();

        // ---------------- reset state ----------------
        rst = 1;
        m0_req = 1; s_addr_ok = 1; s_data_ok = 1;
        #3;
        check("rst_s_req",      {31'd0, s_req},      32'd0);
        check("rst_m0_addr_ok", {31'd0, m0_addr_ok}, 32'd0);
        check("rst_m0_data_ok", {31'd0, m0_data_ok}, 32'd0);
        check("rst_count",      32'(dut.count_q),    32'd0);
        tick();
        tick();
        idle();
        rst = 0;
        #1;
        check("post_rst_resp_err", {31'd0, dut.resp_err_q}, 32'd0);

        // ---------------- simultaneous request: m0 wins ----------------
        tick();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_addr_ok = 1;
        #1;
        check("both_m0_addr_ok", {31'd0, m0_addr_ok}, 32'd1);
        check("both_m1_addr_ok", {31'd0, m1_addr_ok}, 32'd0);
        check("both_s_addr",     s_addr,              32'h100);
        tick();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hDEAD0000;
        #1;
        check("resp_m0_data_ok", {31'd0, m0_data_ok}, 32'd1);
        check("resp_m1_data_ok", {31'd0, m1_data_ok}, 32'd0);
        check("resp_m0_rdata",   m0_rdata,            32'hDEAD0000);
        check("m1_wait_s_addr",  s_addr,              32'h200);
        tick();
        s_addr_ok = 1; s_data_ok = 0;
        #1;
        check("m1_accept",       {31'd0, m1_addr_ok}, 32'd1);
        tick();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000BEEF;
        #1;
        check("m1_resp_data_ok", {31'd0, m1_data_ok}, 32'd1);
        check("m1_resp_m0_dok",  {31'd0, m0_data_ok}, 32'd0);
        check("m1_resp_rdata",   m1_rdata,            32'h0000BEEF);
        tick();
        idle();
        #1;
        check("t1_count", 32'(dut.count_q), 32'd0);

        // ---------------- starvation rescue ----------------
        for (int k = 1; k <= 9; k++) begin
            tick();
            m0_req = 1; m0_addr = 32'h1000 + 32'(k); m1_req = 1; m1_addr = 32'h2000;
            s_addr_ok = 1; s_data_ok = (k > 1);
            #1;
            check($sformatf("starve_m1_ok_c%0d", k), {31'd0, m1_addr_ok}, {31'd0, (k == 9)});
            check($sformatf("starve_m0_ok_c%0d", k), {31'd0, m0_addr_ok}, {31'd0, (k != 9)});
        end
        tick();
        idle();
        s_data_ok = 1;
        #1;
        check("starve_cnt_zero",   32'(dut.starve_cnt_q), 32'd0);
        check("starve_m1_data_ok", {31'd0, m1_data_ok},   32'd1);
        tick();
        idle();
        #1;
        check("t2_count", 32'(dut.count_q), 32'd0);

        // ---------------- lock holds m1's request ----------------
        m1_req = 1; m1_wr = 1; m1_addr = 32'hA0;
        #1;
        check("lock_c1_s_addr", s_addr, 32'hA0);
        for (int c = 2; c <= 3; c++) begin
            tick();
            m0_req = 1; m0_wr = 0; m0_addr = 32'hB0;
            #1;
            check($sformatf("lock_c%0d_s_addr", c), s_addr, 32'hA0);
            check($sformatf("lock_c%0d_s_wr", c), {31'd0, s_wr}, 32'd1);
            check($sformatf("lock_c%0d_m0_ok", c), {31'd0, m0_addr_ok}, 32'd0);
        end
        tick();
        s_addr_ok = 1;
        #1;
        check("lock_accept_m1", {31'd0, m1_addr_ok}, 32'd1);
        check("lock_accept_addr", s_addr, 32'hA0);
        tick();
        m1_req = 0;
        #1;
        check("after_lock_m0_ok", {31'd0, m0_addr_ok}, 32'd1);
        check("after_lock_addr",  s_addr,              32'hB0);
        tick();
        idle();
        s_data_ok = 1;
        #1;
        check("lock_resp1_m1", {31'd0, m1_data_ok}, 32'd1);
        tick();
        #1;
        check("lock_resp2_m0", {31'd0, m0_data_ok}, 32'd1);
        tick();
        idle();

        // ---------------- fill FIFO m0,m1,m1,m0 ----------------
        for (int i = 0; i < 4; i++) begin
            idle();
            s_addr_ok = 1;
            if (i == 0 || i == 3) m0_req = 1; else m1_req = 1;
            tick();
        end
        idle();
        m0_req = 1; s_addr_ok = 1;
        #1;
        check("full_s_req",      {31'd0, s_req},      32'd0);
        check("full_m0_addr_ok", {31'd0, m0_addr_ok}, 32'd0);
        check("full_count",      32'(dut.count_q),    32'd4);
        tick();
        s_data_ok = 1;
        #1;
        check("full_pop_no_bypass", {31'd0, m0_addr_ok}, 32'd0);
        check("full_pop_m0_dok",    {31'd0, m0_data_ok}, 32'd1);
        tick();
        s_data_ok = 0;
        #1;
        check("refill_m0_ok", {31'd0, m0_addr_ok}, 32'd1);
        tick();
        idle();
        #1;
        check("refill_count", 32'(dut.count_q), 32'd4);
        for (int i = 0; i < 4; i++) begin
            s_data_ok = 1;
            #1;
            check($sformatf("drain%0d_m1_dok", i), {31'd0, m1_data_ok}, {31'd0, (i < 2)});
            check($sformatf("drain%0d_m0_dok", i), {31'd0, m0_data_ok}, {31'd0, (i >= 2)});
            tick();
        end
        idle();
        #1;
        check("drained_count", 32'(dut.count_q), 32'd0);

        // ---------------- reset with outstanding work ----------------
        m0_req = 1; s_addr_ok = 1;
        tick();
        idle();
        m1_req = 1; s_addr_ok = 1;
        tick();
        idle();
        m0_req = 1; s_addr_ok = 1; s_data_ok = 1;
        rst = 1;
        #1;
        check("arst_s_req",      {31'd0, s_req},      32'd0);
        check("arst_m0_addr_ok", {31'd0, m0_addr_ok}, 32'd0);
        check("arst_m0_data_ok", {31'd0, m0_data_ok}, 32'd0);
        check("arst_count",      32'(dut.count_q),    32'd0);
        tick();
        rst = 0;
        idle();
        s_data_ok = 1;
        #1;
        check("err_m0_data_ok", {31'd0, m0_data_ok},     32'd0);
        check("err_m1_data_ok", {31'd0, m1_data_ok},     32'd0);
        check("err_before",     {31'd0, dut.resp_err_q}, 32'd0);
        tick();
        s_data_ok = 0;
        #1;
        check("err_set",        {31'd0, dut.resp_err_q}, 32'd1);
        check("err_count",      32'(dut.count_q),        32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
